sound_mixer: RTL

SOUND_MIXER -- requirements
Module: sound_mixer

---
 rtl/sound_mixer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/sound_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : sound_mixer
//  Purpose  : Game-Boy style four-channel stereo mixer. On each sample_strobe
//             the channel levels and panning/volume registers are captured,
//             summed per side, scaled by master volume and pushed into a
//             small stereo sample FIFO drained by a valid/ready consumer.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    FIFO_DEPTH      stereo entries buffered (power of two, 2..16)
//  Ports
//    clk             single clock
//    reset           synchronous active-high reset
//    sample_strobe   one-cycle request for one mixed stereo sample
//    ch1..4_level    4-bit channel output levels
//    nr50            [6:4] left volume, [2:0] right volume (7,3 ignored)
//    nr51            [7:4] left enables ch4..ch1, [3:0] right enables ch4..ch1
//    sound_enable    master on (NR52 bit 7)
//    out_valid       FIFO head holds a sample
//    out_ready       consumer accepts head this cycle
//    out_left/right  head sample
//    fifo_count      occupied entries
//    overflow        sticky dropped-sample flag
//    overflow_clear  clears overflow
//  Build option
//    SOUND_MIXER_DC_CENTER_EN  when defined, samples are two's-complement
//                              centred on zero: (product<<7) - 30720
// ============================================================================
module sound_mixer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            sample_strobe,
    input  logic [3:0]                      ch1_level,
    input  logic [3:0]                      ch2_level,
    input  logic [3:0]                      ch3_level,
    input  logic [3:0]                      ch4_level,
    input  logic [7:0]                      nr50,
    input  logic [7:0]                      nr51,
    input  logic                            sound_enable,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [15:0]                     out_left,
    output logic [15:0]                     out_right,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow,
    input  logic                            overflow_clear
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // nr50 bits 7 and 3 (VIN routing) have no effect on the mix
    logic unused_nr50_bits;
    assign unused_nr50_bits = nr50[7] ^ nr50[3];

    // ------------------------------------------------------------------
    // S1: capture inputs on the strobe
    // ------------------------------------------------------------------
    logic       s1_valid;
    logic [3:0] s1_l1, s1_l2, s1_l3, s1_l4;
    logic [2:0] s1_vol_l, s1_vol_r;
    logic [7:0] s1_nr51;
    logic       s1_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= sample_strobe;
        end
        if (sample_strobe) begin
            s1_l1    <= ch1_level;
            s1_l2    <= ch2_level;
            s1_l3    <= ch3_level;
            s1_l4    <= ch4_level;
            s1_vol_l <= nr50[6:4];
            s1_vol_r <= nr50[2:0];
            s1_nr51  <= nr51;
            s1_en    <= sound_enable;
        end
    end

    // ------------------------------------------------------------------
    // S2: per-side sum of enabled channels (mask bit 0 = ch1 ... 3 = ch4)
    // ------------------------------------------------------------------
    function automatic logic [5:0] side_sum(input logic [3:0] mask,
                                            input logic [3:0] a,
                                            input logic [3:0] b,
                                            input logic [3:0] c,
                                            input logic [3:0] d);
        side_sum = {2'b00, a & {4{mask[0]}}} + {2'b00, b & {4{mask[1]}}}
                 + {2'b00, c & {4{mask[2]}}} + {2'b00, d & {4{mask[3]}}};
    endfunction

    logic       s2_valid;
    logic [5:0] s2_sum_l, s2_sum_r;
    logic [2:0] s2_vol_l, s2_vol_r;
    logic       s2_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
        end
        s2_sum_l <= side_sum(s1_nr51[7:4], s1_l1, s1_l2, s1_l3, s1_l4);
        s2_sum_r <= side_sum(s1_nr51[3:0], s1_l1, s1_l2, s1_l3, s1_l4);
        s2_vol_l <= s1_vol_l;
        s2_vol_r <= s1_vol_r;
        s2_en    <= s1_en;
    end

    // ------------------------------------------------------------------
    // S3: scale by (volume + 1); 60 * 8 = 480 fits in 9 bits
    // ------------------------------------------------------------------
    logic       s3_valid;
    logic [8:0] s3_prod_l, s3_prod_r;
    logic       s3_en;
    logic [3:0] vol_l_p1, vol_r_p1;

    assign vol_l_p1 = {1'b0, s2_vol_l} + 4'd1;
    assign vol_r_p1 = {1'b0, s2_vol_r} + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            s3_valid <= 1'b0;
        end else begin
            s3_valid <= s2_valid;
        end
        s3_prod_l <= {3'b000, s2_sum_l} * {5'b00000, vol_l_p1};
        s3_prod_r <= {3'b000, s2_sum_r} * {5'b00000, vol_r_p1};
        s3_en     <= s2_en;
    end

    // ------------------------------------------------------------------
    // Sample formatting
    // ------------------------------------------------------------------
    logic [15:0] raw_l, raw_r, smp_l, smp_r;

    assign raw_l = {s3_prod_l, 7'b0000000};
    assign raw_r = {s3_prod_r, 7'b0000000};

`ifdef SOUND_MIXER_DC_CENTER_EN
    // Modulo-2^16 subtraction yields the two's-complement result directly
    assign smp_l = s3_en ? (raw_l - 16'd30720) : 16'h0000;
    assign smp_r = s3_en ? (raw_r - 16'd30720) : 16'h0000;
`else
    assign smp_l = s3_en ? raw_l : 16'h0000;
    assign smp_r = s3_en ? raw_r : 16'h0000;
`endif

    // ------------------------------------------------------------------
    // Sample FIFO
    // ------------------------------------------------------------------
    logic [15:0]      mem_l [FIFO_DEPTH];
    logic [15:0]      mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full, rd_en, wr_en, drop;

    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign rd_en = out_valid & out_ready;
    // A write into a full FIFO still succeeds when the head leaves this cycle
    assign wr_en = s3_valid & (~full | rd_en);
    assign drop  = s3_valid & full & ~rd_en;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_l[wr_ptr] <= smp_l;
            mem_r[wr_ptr] <= smp_r;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            // Power-of-two depth: pointer wrap is natural overflow
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear wins
            if (drop)
                overflow <= 1'b1;
            else if (overflow_clear)
                overflow <= 1'b0;
        end
    end

    assign out_valid  = (count != '0);
    assign fifo_count = count;
    assign out_left   = out_valid ? mem_l[rd_ptr] : 16'h0000;
    assign out_right  = out_valid ? mem_r[rd_ptr] : 16'h0000;

endmodule
`default_nettype wire
